// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// using a single full-subtractor cell and a borrow flop. A start/busy/done
// handshake frames each operation; results are held until the next one ends.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             a0, b0, d_bit, br_next;
  logic [WIDTH-1:0] sr_shift;

  // Full-subtractor cell on the current LSBs; the result bit enters at the MSB.
  // Written as shift/OR rather than a slice so WIDTH=1 needs no special case.
  always_comb begin
    a0       = sa_q[0];
    b0       = sb_q[0];
    d_bit    = a0 ^ b0 ^ br_q;
    br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    sr_shift = (sr_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = br_next;
        sr_d  = sr_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          diff_d  = sr_shift;
          bout_d  = br_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
